pwr_reg_target: RTL and testbench
=================================

# pwr_reg_target

AXI-Lite responder holding the power-control register bank, sitting on the far end of the power controller's AXI-Lite master port inside the banzAI control subsystem. It accepts single-beat AXI-Lite reads and writes, applies byte strobes to a bank of `REG_NUM` 32-bit registers, and returns OKAY/SLVERR responses. It exposes the full bank and per-register write pulses to downstream power-switch logic.

## Interface
- `ADDR_WIDTH`, 32: AXI-Lite address width.
- `DATA_WIDTH`, 32: data width; fixed at 32, 4 strobe bits.
- `REG_NUM`, 16: number of registers.
- `BASE_ADDR`, 0: byte address of register 0; must be 4-byte aligned.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `aw_addr` in ADDR_WIDTH, `aw_prot` in 3 (ignored), `aw_valid` in 1, `aw_ready` out 1: write address channel.
- `w_data` in 32, `w_strb` in 4, `w_valid` in 1, `w_ready` out 1: write data channel.
- `b_resp` out 2, `b_valid` out 1, `b_ready` in 1: write response channel.
- `ar_addr` in ADDR_WIDTH, `ar_prot` in 3 (ignored), `ar_valid` in 1, `ar_ready` out 1: read address channel.
- `r_data` out 32, `r_resp` out 2, `r_valid` out 1, `r_ready` in 1: read data channel.
- `reg_q` out REG_NUM*32: current register contents; register i is at bits [32i+31:32i].
- `reg_wr_pulse` out REG_NUM: one-cycle pulse on the index written by a successful write.

## Operation
- Decode: `off = addr - BASE_ADDR`; `idx = off[ADDR_WIDTH-1:2]`; `off[1:0]` is ignored. An address is out of range if `addr < BASE_ADDR` or `idx >= REG_NUM`.
- Write FSM states:
  - W_IDLE:
    - AW and W are accepted independently, in either order or in the same cycle.
    - Each accepted channel is latched, and its ready drops until the transaction completes.
    - When both are held, or arrive, in cycle T: the write executes at the end of T and the FSM moves to W_RESP.
  - W_RESP:
    - `b_valid` is 1 and `b_resp` is stable until `b_ready`.
    - On the B handshake the FSM returns to W_IDLE.
- Write effect:
  - In range: for each byte k with `w_strb[k]` set, `reg[idx][8k+7:8k]` takes `w_data[8k+7:8k]`.
  - In range: `b_resp` is 2'b00 and `reg_wr_pulse[idx]` is 1 for exactly cycle T+1. The pulse fires even when `w_strb` is 0.
  - Out of range: no register change, no pulse, `b_resp` is 2'b10.
- Read FSM states:
  - R_IDLE: `ar_ready` is 1. An AR handshake in cycle T registers `r_data`/`r_resp` and moves the FSM to R_DATA.
  - R_DATA: `r_valid` is 1 and the data is stable until `r_ready`. Then the FSM returns to R_IDLE.
- Read data:
  - In range: the register value sampled in cycle T, with `r_resp` 2'b00.
  - Out of range: `r_data` is 0 and `r_resp` is 2'b10.
- Simultaneous read and write: the read and write FSMs are fully independent. A read and a write to the same register completing in the same cycle T returns the pre-write value.
- `aw_prot`/`ar_prot` do not affect behaviour.

## Timing
- While `rst_n` is 0:
  - All registers are 0 and the FSMs are in their IDLE states.
  - `b_valid`, `r_valid` and `reg_wr_pulse` are 0; `b_resp`, `r_resp` and `r_data` are 0.
  - `aw_ready`, `w_ready` and `ar_ready` are forced to 0.
- Readies are 1 in the first cycle with `rst_n` high.
- Write latency:
  - AW and W both handshaking in cycle T gives `reg_q` updated and `b_valid` set at T+1.
  - If `b_ready` is 1 at T+1, `aw_ready`/`w_ready` return at T+2.
  - Peak throughput is one write per 2 cycles.
- Read latency: AR handshake at T gives `r_valid` at T+1. With `r_ready` high, `ar_ready` returns at T+2.
- Readies are not combinationally dependent on the valids. The readies depend only on FSM state and the held flags.
- Reset asserted mid-transaction:
  - Any pending response is abandoned and all state is cleared on the next edge.
  - No response is issued after `rst_n` returns high.
- Backpressure: `b_valid`/`r_valid` and their payloads never change or drop before the handshake.

## Test plan
- Reset, then read all 16 registers: every R beat returns `r_data` 0 with `r_resp` 00, and `r_valid` rises exactly 1 cycle after each AR handshake.
- AW at T, W at T+3, `b_ready` held 0 for 4 cycles:
  - No write happens before T+3.
  - `b_valid` rises at T+4 and stays stable until `b_ready`.
  - `reg_wr_pulse[idx]` pulses exactly once, at T+4.
- Write 0xA5A5A5A5 to reg 5, then write 0x11223344 with `w_strb` 4'b0101: reading reg 5 returns 0xA522A544.
- Write to `BASE_ADDR` + 0x40 (idx 16) and read from `BASE_ADDR` − 4:
  - Both return SLVERR (2'b10).
  - The read data is 0.
  - No `reg_wr_pulse` fires and `reg_q` is unchanged.
- Same-cycle AW+W and AR to reg 3 (old value 0x0, new value 0xDEADBEEF): R returns 0x0, and the next read returns 0xDEADBEEF.
- Assert `rst_n` low while `r_valid` is held with `r_ready` 0: the next cycle has `r_valid` 0 and `reg_q` all 0, and no stale R beat appears after release.

Source files
------------

// File: rtl/pwr_reg_target.sv
// AXI-Lite responder for the power-control register bank. Independent read and
// write channels, byte-strobed writes, and a per-register write pulse.
module pwr_reg_target #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_NUM    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         aw_addr,
  input  logic [2:0]                    aw_prot,
  input  logic                          aw_valid,
  output logic                          aw_ready,
  input  logic [DATA_WIDTH-1:0]         w_data,
  input  logic [DATA_WIDTH/8-1:0]       w_strb,
  input  logic                          w_valid,
  output logic                          w_ready,
  output logic [1:0]                    b_resp,
  output logic                          b_valid,
  input  logic                          b_ready,
  input  logic [ADDR_WIDTH-1:0]         ar_addr,
  input  logic [2:0]                    ar_prot,
  input  logic                          ar_valid,
  output logic                          ar_ready,
  output logic [DATA_WIDTH-1:0]         r_data,
  output logic [1:0]                    r_resp,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_q,
  output logic [REG_NUM-1:0]            reg_wr_pulse
);

  localparam int unsigned IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(REG_NUM * 4);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Byte offset below SPAN covers exactly idx < REG_NUM, low address bits ignored.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  w_state_e                w_state_q, w_state_d;
  r_state_e                r_state_q, r_state_d;
  logic                    aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic [1:0]              b_resp_q, r_resp_q;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic [REG_NUM-1:0]      pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0]   regs_q [REG_NUM];
  logic [DATA_WIDTH-1:0]   regs_d [REG_NUM];

  logic                    aw_hs, w_hs, ar_hs, wr_fire, wr_ok;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data, wr_mask;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic [IDX_W-1:0]        wr_idx;
  logic                    unused_prot;

  assign unused_prot = ^{aw_prot, ar_prot};

  // Readies come from state only; rst_n gating keeps them low while in reset.
  assign aw_ready = rst_n && (w_state_q == W_IDLE) && !aw_held_q;
  assign w_ready  = rst_n && (w_state_q == W_IDLE) && !w_held_q;
  assign ar_ready = rst_n && (r_state_q == R_IDLE);
  assign aw_hs    = aw_valid && aw_ready;
  assign w_hs     = w_valid && w_ready;
  assign ar_hs    = ar_valid && ar_ready;

  assign wr_addr = aw_held_q ? aw_addr_q : aw_addr;
  assign wr_data = w_held_q ? w_data_q : w_data;
  assign wr_strb = w_held_q ? w_strb_q : w_strb;
  assign wr_fire = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_ok   = wr_fire && addr_ok(wr_addr);
  assign wr_idx  = addr_idx(wr_addr);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH/8; gi++) begin : g_mask
      assign wr_mask[8*gi +: 8] = {8{wr_strb[gi]}};
    end
    for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
      logic sel;
      assign sel          = wr_ok && (wr_idx == IDX_W'(gi));
      assign regs_d[gi]   = sel ? ((regs_q[gi] & ~wr_mask) | (wr_data & wr_mask)) : regs_q[gi];
      assign pulse_d[gi]  = sel;
      assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end
  endgenerate

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (wr_fire) w_state_d = W_RESP;
      W_RESP:  if (b_ready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_ready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= 2'b00;
      pulse_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) aw_addr_q <= aw_addr;
      if (w_hs) begin
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
      aw_held_q <= wr_fire ? 1'b0 : (aw_held_q || aw_hs);
      w_held_q  <= wr_fire ? 1'b0 : (w_held_q || w_hs);
      if (wr_fire) b_resp_q <= wr_ok ? 2'b00 : 2'b10;
      pulse_q   <= pulse_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read samples the bank before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      r_data_q  <= '0;
      r_resp_q  <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_data_q <= addr_ok(ar_addr) ? regs_q[addr_idx(ar_addr)] : '0;
        r_resp_q <= addr_ok(ar_addr) ? 2'b00 : 2'b10;
      end
    end
  end

  assign b_valid      = (w_state_q == W_RESP);
  assign b_resp       = b_resp_q;
  assign r_valid      = (r_state_q == R_DATA);
  assign r_data       = r_data_q;
  assign r_resp       = r_resp_q;
  assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_pwr_reg_target.sv
// Bench for pwr_reg_target: scoreboard queues fed at issue time, drained by a
// negedge monitor; expectations come from an array model of the bank.
module tb_pwr_reg_target;
  localparam int N = 16;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [31:0]   aw_addr, w_data, ar_addr, r_data;
  logic [2:0]    aw_prot, ar_prot;
  logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic          ar_valid, ar_ready, r_valid, r_ready;
  logic [3:0]    w_strb;
  logic [1:0]    b_resp, r_resp;
  logic [N*32-1:0] reg_q;
  logic [N-1:0]  reg_wr_pulse;

  pwr_reg_target #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(N), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model [N];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  int          pulse_cnt = 0;
  logic [N-1:0] pulse_last = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < N);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [N*32-1:0] model_flat();
    logic [N*32-1:0] f;
    for (int i = 0; i < N; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  // Monitor: pops on each handshake, checks payload stability under backpressure.
  logic        r_hold = 1'b0, b_hold = 1'b0;
  logic [33:0] r_hold_v, mon_r;
  logic [1:0]  b_hold_v, mon_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      r_hold = 1'b0;
      b_hold = 1'b0;
    end else begin
      if (r_hold) check("r_stable", {r_valid, r_resp, r_data}, {1'b1, r_hold_v});
      if (b_hold) check("b_stable", {b_valid, b_resp}, {1'b1, b_hold_v});
      if (r_valid && r_ready) begin
        if (exp_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got beat %h expected none", {r_resp, r_data});
        end else begin
          mon_r = exp_r.pop_front();
          $display("R beat resp=%0d data=%h (expected resp=%0d data=%h)", r_resp, r_data, mon_r[33:32], mon_r[31:0]);
          check("r_beat", {r_resp, r_data}, mon_r);
        end
      end
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got resp %0d expected none", b_resp);
        end else begin
          mon_b = exp_b.pop_front();
          $display("B beat resp=%0d (expected %0d)", b_resp, mon_b);
          check("b_beat", b_resp, mon_b);
        end
      end
      r_hold = r_valid && !r_ready; r_hold_v = {r_resp, r_data};
      b_hold = b_valid && !b_ready; b_hold_v = b_resp;
      if (reg_wr_pulse != '0) begin
        pulse_cnt++;
        pulse_last = reg_wr_pulse;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input bit bp);
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 60) begin
      b_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      r_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    check("resp_timeout", n < 60, 1);
    b_ready = 1'b1;
    r_ready = 1'b1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input bit bp);
    int n = 0;
    int pc0;
    bit aw_done = 0, w_done = 0;
    bit ok = m_in_range(addr);
    int idx = m_idx(addr);
    exp_b.push_back(ok ? 2'b00 : 2'b10);
    if (ok) for (int k = 0; k < 4; k++) if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    pc0 = pulse_cnt;
    aw_addr = addr; aw_prot = 3'($urandom); aw_valid = 1'b1;
    w_data = data; w_strb = strb; w_valid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      if (aw_valid && aw_ready) aw_done = 1;
      if (w_valid && w_ready) w_done = 1;
      step();
      if (aw_done) aw_valid = 1'b0;
      if (w_done) w_valid = 1'b0;
      n++;
    end
    check("wr_accept_timeout", n < 20, 1);
    wait_idle(bp);
    check("wr_pulse_count", pulse_cnt - pc0, ok ? 1 : 0);
    if (ok) check("wr_pulse_index", pulse_last, N'(1) << idx);
    check("wr_reg_bank", reg_q, model_flat());
  endtask

  task automatic do_read(input logic [31:0] addr, input bit bp);
    int n = 0;
    bit done = 0;
    bit ok = m_in_range(addr);
    exp_r.push_back(ok ? {2'b00, model[m_idx(addr)]} : {2'b10, 32'h0});
    ar_addr = addr; ar_prot = 3'($urandom); ar_valid = 1'b1;
    while (!done && n < 20) begin
      @(negedge clk);
      if (ar_ready) begin
        done = 1;
        check("r_valid_before_hs", r_valid, 0);
      end
      step();
      n++;
    end
    ar_valid = 1'b0;
    check("rd_accept_timeout", n < 20, 1);
    @(negedge clk);
    check("r_valid_latency", r_valid, 1);
    wait_idle(bp);
  endtask

  initial begin
    int pc0;
    logic [31:0] d, old, a;
    rst_n = 1'b0;
    aw_addr = '0; aw_prot = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_valid = 1'b0; b_ready = 1'b1;
    ar_addr = '0; ar_prot = '0; ar_valid = 1'b0; r_ready = 1'b1;
    for (int i = 0; i < N; i++) model[i] = '0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_handshake", {aw_ready, w_ready, ar_ready, b_valid, r_valid, reg_wr_pulse}, '0);
    check("rst_payload", {b_resp, r_resp, r_data}, '0);
    check("rst_regs", reg_q, '0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("readies_after_rst", {aw_ready, w_ready, ar_ready}, 3'b111);
    step();
    for (int i = 0; i < N; i++) do_read(BASE + 32'(i * 4), 0);

    // AW at T, W at T+3, B backpressured for four cycles
    old = model[7];
    d = $urandom;
    b_ready = 1'b0;
    exp_b.push_back(2'b00);
    model[7] = d;
    pc0 = pulse_cnt;
    aw_addr = BASE + 32'd28; aw_valid = 1'b1;
    @(negedge clk);
    check("t2_aw_ready", aw_ready, 1);
    step();
    aw_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check("t2_no_early_write", {b_valid, reg_wr_pulse, reg_q[7*32 +: 32]}, {1'b0, 16'h0, old});
      check("t2_ready_hold", {aw_ready, w_ready}, 2'b01);
      step();
    end
    w_data = d; w_strb = 4'hF; w_valid = 1'b1;
    @(negedge clk);
    check("t2_t3_state", {b_valid, w_ready, reg_q[7*32 +: 32]}, {1'b0, 1'b1, old});
    step();
    w_valid = 1'b0;
    @(negedge clk);
    check("t2_t4_effect", {b_valid, b_resp, reg_wr_pulse, reg_q[7*32 +: 32]}, {1'b1, 2'b00, 16'h0080, d});
    for (int c = 5; c <= 7; c++) begin
      step();
      @(negedge clk);
      check("t2_b_held", {b_valid, b_resp, reg_wr_pulse, aw_ready, w_ready}, {1'b1, 2'b00, 16'h0, 2'b00});
    end
    step();
    b_ready = 1'b1;
    wait_idle(0);
    check("t2_single_pulse", pulse_cnt - pc0, 1);

    // Byte strobes
    do_write(BASE + 32'd20, 32'hA5A5_A5A5, 4'hF, 0);
    do_write(BASE + 32'd20, 32'h1122_3344, 4'b0101, 0);
    check("t3_reg5_value", reg_q[5*32 +: 32], 32'hA522_A544);
    do_read(BASE + 32'd20, 0);

    // Out-of-range accesses on both sides
    do_write(BASE + 32'h40, $urandom, 4'hF, 0);
    do_read(BASE - 32'd4, 0);

    // Same-cycle write and read of reg 3
    exp_r.push_back({2'b00, model[3]});
    exp_b.push_back(2'b00);
    model[3] = 32'hDEAD_BEEF;
    aw_addr = BASE + 32'd12; aw_valid = 1'b1;
    w_data = 32'hDEAD_BEEF; w_strb = 4'hF; w_valid = 1'b1;
    ar_addr = BASE + 32'd12; ar_valid = 1'b1;
    @(negedge clk);
    check("t5_all_ready", {aw_ready, w_ready, ar_ready}, 3'b111);
    step();
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    wait_idle(0);
    check("t5_reg_bank", reg_q, model_flat());
    do_read(BASE + 32'd12, 0);

    // Randomized traffic with random backpressure
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) == 0) a = BASE - 32'($urandom_range(1, 4) * 4);
      else a = BASE + 32'($urandom_range(0, 19) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom), 1);
      else do_read(a, 1);
    end

    // Reset while an R beat is stalled
    r_ready = 1'b0;
    ar_addr = BASE + 32'd20; ar_valid = 1'b1;
    @(negedge clk);
    check("t7_ar_ready", ar_ready, 1);
    step();
    ar_valid = 1'b0;
    @(negedge clk);
    check("t7_r_stalled", r_valid, 1);
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("t7_rst_clears", {r_valid, b_valid, ar_ready, reg_wr_pulse}, '0);
    check("t7_rst_regs", reg_q, '0);
    for (int i = 0; i < N; i++) model[i] = '0;
    step();
    rst_n = 1'b1;
    r_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t7_no_stale_r", r_valid, 0);
      step();
    end
    do_read(BASE + 32'd20, 0);

    check("queues_drained", exp_b.size() + exp_r.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
